// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and writeback bundle for the ALU op sequencer.
// master = sequencer side, slave = requester / ALU / writeback sink side.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_result;

  logic        wb_valid;
  logic        wb_ready;
  logic        wb_sel;
  logic [31:0] wb_data;

  logic        busy;
  logic        err;

  modport master (
    input  req_valid, req_op, req_a, req_b, alu_result, wb_ready,
    output req_ready, alu_a, alu_b, alu_opcode, wb_valid, wb_sel, wb_data, busy, err
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, alu_result, wb_ready,
    input  req_ready, alu_a, alu_b, alu_opcode, wb_valid, wb_sel, wb_data, busy, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issuer: latches an op, holds it on the ALU for ALU_WAIT cycles,
// captures the 64-bit result and writes it back as one or two 32-bit beats.
module alu_op_sequencer #(
  parameter int unsigned ALU_WAIT = 1,
  parameter logic [4:0]  OP_MUL   = 5'b01111,
  parameter logic [4:0]  OP_DIV   = 5'b10000
) (
  input logic                 clk,
  input logic                 clr,
  alu_op_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_CAPT, S_WB_LO, S_WB_HI, S_ERR
  } state_e;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] y;
    logic [31:0] b;
  } req_t;

  localparam logic [3:0] WAIT_LD = 4'(ALU_WAIT);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [63:0] z_q, z_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000,
      5'b10001, 5'b10010: op_legal = 1'b1;
      default:            op_legal = 1'b0;
    endcase
  endfunction

  wire two_beat = (req_q.op == OP_MUL) || (req_q.op == OP_DIV);
  wire accept   = bus.req_valid && ready_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_d = '{op: bus.req_op, y: bus.req_a, b: bus.req_b};
          if (op_legal(bus.req_op)) begin
            state_d = S_EXEC;
            cnt_d   = WAIT_LD;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        // <=1 rather than ==1 so a zero load cannot wrap into a 16-cycle stall
        if (cnt_q <= 4'd1) state_d = S_CAPT;
      end
      S_CAPT: begin
        z_d     = bus.alu_result;
        state_d = S_WB_LO;
      end
      S_WB_LO: if (bus.wb_ready) state_d = two_beat ? S_WB_HI : S_IDLE;
      S_WB_HI: if (bus.wb_ready) state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // registered so ready stays low through reset and rises one edge after clr drops
    ready_d = (state_d == S_IDLE);
  end

  always_comb begin
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_opcode = '0;
    bus.wb_valid   = 1'b0;
    bus.wb_sel     = 1'b0;
    bus.wb_data    = '0;
    bus.err        = 1'b0;
    case (state_q)
      S_EXEC, S_CAPT: begin
        bus.alu_a      = req_q.y;
        bus.alu_b      = req_q.b;
        bus.alu_opcode = req_q.op;
      end
      S_WB_LO: begin
        bus.wb_valid = 1'b1;
        bus.wb_data  = z_q[31:0];
      end
      S_WB_HI: begin
        bus.wb_valid = 1'b1;
        bus.wb_sel   = 1'b1;
        bus.wb_data  = z_q[63:32];
      end
      S_ERR:   bus.err = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = (state_q != S_IDLE);

  a_wb_hold: assert property (@(posedge clk) disable iff (clr)
    (bus.wb_valid && !bus.wb_ready) |=> (bus.wb_valid && $stable(bus.wb_data) && $stable(bus.wb_sel)));

  a_err_pulse: assert property (@(posedge clk) disable iff (clr)
    bus.err |=> !bus.err);

  a_ready_idle: assert property (@(posedge clk) disable iff (clr)
    bus.req_ready |-> !bus.busy);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: table of single ops on an ALU_WAIT=1 instance, plus
// hand sequences for backpressure, a longer ALU_WAIT and clr mid-writeback.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if if1();
  alu_op_sequencer_if if4();

  alu_op_sequencer #(.ALU_WAIT(1)) dut1 (.clk(clk), .clr(clr), .bus(if1.master));
  alu_op_sequencer #(.ALU_WAIT(4)) dut4 (.clk(clk), .clr(clr), .bus(if4.master));

  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    case (op)
      5'b00011: r = {32'd0, a + b};
      5'b00100: r = {32'd0, a - b};
      5'b00101: r = {32'd0, a & b};
      5'b00110: r = {32'd0, a | b};
      5'b00111: r = {32'd0, a ^ b};
      5'b01001: r = {32'd0, a << b[4:0]};
      5'b01010: r = {32'd0, a >> b[4:0]};
      5'b01011: r = {32'd0, $signed(a) >>> b[4:0]};
      5'b01111: r = {32'd0, a} * {32'd0, b};
      5'b10000: r = (b == 0) ? 64'd0 : {a % b, a / b};
      5'b10001: r = {63'd0, a < b};
      5'b10010: r = {63'd0, a == b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  always_comb if1.alu_result = alu_model(if1.alu_opcode, if1.alu_a, if1.alu_b);
  always_comb if4.alu_result = alu_model(if4.alu_opcode, if4.alu_a, if4.alu_b);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        two;
    logic        ill;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  // Starts and ends at a negedge with dut1 idle and wb_ready high.
  task automatic run_vec(input vec_t v);
    chk("ready_pre", if1.req_ready, 1);
    if1.req_valid = 1'b1; if1.req_op = v.op; if1.req_a = v.a; if1.req_b = v.b;
    @(posedge clk); #1 if1.req_valid = 1'b0;
    @(negedge clk);
    if (v.ill) begin
      chk("err_c1", if1.err, 1);
      chk("ill_wbv", if1.wb_valid, 0);
      chk("ill_aluop", if1.alu_opcode, 0);
      chk("ill_ready", if1.req_ready, 0);
      @(negedge clk);
      chk("err_c2", if1.err, 0);
      chk("ill_ready_back", if1.req_ready, 1);
      chk("ill_busy", if1.busy, 0);
    end else begin
      chk("exec_op", if1.alu_opcode, v.op);
      chk("exec_a", if1.alu_a, v.a);
      chk("exec_b", if1.alu_b, v.b);
      chk("exec_ready", if1.req_ready, 0);
      chk("exec_busy", if1.busy, 1);
      @(negedge clk);
      chk("capt_op", if1.alu_opcode, v.op);
      chk("capt_wbv", if1.wb_valid, 0);
      @(negedge clk);
      chk("lo_valid", if1.wb_valid, 1);
      chk("lo_sel", if1.wb_sel, 0);
      chk("lo_data", if1.wb_data, v.lo);
      chk("lo_aluop", if1.alu_opcode, 0);
      if (v.two) begin
        @(negedge clk);
        chk("hi_valid", if1.wb_valid, 1);
        chk("hi_sel", if1.wb_sel, 1);
        chk("hi_data", if1.wb_data, v.hi);
      end
      @(negedge clk);
      chk("done_busy", if1.busy, 0);
      chk("done_wbv", if1.wb_valid, 0);
      chk("done_ready", if1.req_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drv_cnt;
    int first_wb;
    logic [31:0] wb4;

    tbl[0]  = '{5'b00011, 32'd5,          32'd7,          1'b0, 1'b0, 32'd12,         32'd0};
    tbl[1]  = '{5'b01111, 32'h0001_0000,  32'h0001_0000,  1'b1, 1'b0, 32'h0,          32'h1};
    tbl[2]  = '{5'b11111, 32'd1,          32'd1,          1'b0, 1'b1, 32'd0,          32'd0};
    tbl[3]  = '{5'b00101, 32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0, 1'b0, 32'h0F00_0F00,  32'd0};
    tbl[4]  = '{5'b00111, 32'hFFFF_0000,  32'h00FF_FF00,  1'b0, 1'b0, 32'hFF00_FF00,  32'd0};
    tbl[5]  = '{5'b01001, 32'd1,          32'd4,          1'b0, 1'b0, 32'h10,         32'd0};
    tbl[6]  = '{5'b10000, 32'd100,        32'd7,          1'b1, 1'b0, 32'd14,         32'd2};
    tbl[7]  = '{5'b01111, 32'hFFFF_FFFF,  32'd2,          1'b1, 1'b0, 32'hFFFF_FFFE,  32'h1};
    tbl[8]  = '{5'b00000, 32'd9,          32'd9,          1'b0, 1'b1, 32'd0,          32'd0};
    tbl[9]  = '{5'b10001, 32'd3,          32'd9,          1'b0, 1'b0, 32'd1,          32'd0};
    tbl[10] = '{5'b01010, 32'h8000_0000,  32'd31,         1'b0, 1'b0, 32'd1,          32'd0};

    if1.req_valid = 1'b0; if1.req_op = '0; if1.req_a = '0; if1.req_b = '0; if1.wb_ready = 1'b1;
    if4.req_valid = 1'b0; if4.req_op = '0; if4.req_a = '0; if4.req_b = '0; if4.wb_ready = 1'b1;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_alu_a", if1.alu_a, 0);
    chk("rst_alu_b", if1.alu_b, 0);
    chk("rst_aluop", if1.alu_opcode, 0);
    chk("rst_wbv", if1.wb_valid, 0);
    chk("rst_sel", if1.wb_sel, 0);
    chk("rst_data", if1.wb_data, 0);
    chk("rst_busy", if1.busy, 0);
    chk("rst_err", if1.err, 0);
    chk("rst_ready", if1.req_ready, 0);
    clr = 1'b0;
    #1 chk("ready_before_edge", if1.req_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", if1.req_ready, 1);
    chk("ready_after_edge4", if4.req_ready, 1);

    for (int i = 0; i < NV; i++) run_vec(tbl[i]);

    // backpressure on a single-beat sub, with a second request held meanwhile
    if1.wb_ready = 1'b0;
    if1.req_valid = 1'b1; if1.req_op = 5'b00100; if1.req_a = 32'd3; if1.req_b = 32'd5;
    @(posedge clk); #1;
    if1.req_op = 5'b00011; if1.req_a = 32'd5; if1.req_b = 32'd7;
    @(negedge clk); chk("bp_ready_c1", if1.req_ready, 0);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_valid", if1.wb_valid, 1);
      chk("bp_data", if1.wb_data, 32'hFFFF_FFFE);
      chk("bp_sel", if1.wb_sel, 0);
      chk("bp_ready", if1.req_ready, 0);
    end
    @(negedge clk);
    chk("bp_valid_c7", if1.wb_valid, 1);
    chk("bp_data_c7", if1.wb_data, 32'hFFFF_FFFE);
    if1.wb_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_busy", if1.busy, 0);
    chk("bp_idle_wbv", if1.wb_valid, 0);
    chk("bp_idle_ready", if1.req_ready, 1);
    @(posedge clk); #1 if1.req_valid = 1'b0;
    @(negedge clk);
    chk("held_op", if1.alu_opcode, 5'b00011);
    @(negedge clk); @(negedge clk);
    chk("held_valid", if1.wb_valid, 1);
    chk("held_data", if1.wb_data, 32'd12);
    @(negedge clk);
    chk("held_done", if1.busy, 0);

    // ALU_WAIT=4 instance
    drv_cnt = 0; first_wb = 0; wb4 = '0;
    if4.req_valid = 1'b1; if4.req_op = 5'b00110; if4.req_a = 32'hF0; if4.req_b = 32'h0F;
    @(posedge clk); #1 if4.req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (if4.alu_opcode == 5'b00110 && if4.alu_a == 32'hF0 && if4.alu_b == 32'h0F) drv_cnt++;
      if (if4.wb_valid && first_wb == 0) begin
        first_wb = c;
        wb4 = if4.wb_data;
      end
    end
    chk("w4_drive_cycles", 64'(drv_cnt), 5);
    chk("w4_first_wb", 64'(first_wb), 6);
    chk("w4_data", wb4, 32'hFF);
    chk("w4_idle", if4.busy, 0);

    // clr during WB_LO of a div
    if1.wb_ready = 1'b0;
    if1.req_valid = 1'b1; if1.req_op = 5'b10000; if1.req_a = 32'd100; if1.req_b = 32'd7;
    @(posedge clk); #1 if1.req_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("clr_pre_valid", if1.wb_valid, 1);
    chk("clr_pre_data", if1.wb_data, 32'd14);
    #2 clr = 1'b1;
    #1;
    chk("clr_wbv", if1.wb_valid, 0);
    chk("clr_data", if1.wb_data, 0);
    chk("clr_busy", if1.busy, 0);
    chk("clr_ready", if1.req_ready, 0);
    @(negedge clk);
    clr = 1'b0; if1.wb_ready = 1'b1;
    @(negedge clk);
    chk("clr_ready_back", if1.req_ready, 1);
    chk("clr_no_hi", if1.wb_valid, 0);
    @(negedge clk);
    chk("clr_no_hi2", if1.wb_valid, 0);
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle issuer on the driving side of the datapath ALU.
- Accepts one operation request: opcode plus A and B operands.
- Holds the operands in internal Y/B registers and drives them with the opcode into the combinational ALU for a settle window, then captures the 64-bit ALU result into an internal Z register.
- Writes Z back as one 32-bit beat (LO), or two beats (LO then HI) for mul/div, over a valid/ready writeback port.

Parameters:
- ALU_WAIT, 1, cycles operands/opcode are held before Z capture (1..15).
- OP_MUL, 5'b01111, opcode needing two-beat writeback.
- OP_DIV, 5'b10000, opcode needing two-beat writeback.

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_op  in  5  ALU opcode
- req_a  in  32  operand A
- req_b  in  32  operand B
- alu_a  out  32  operand A to ALU
- alu_b  out  32  operand B to ALU
- alu_opcode  out  5  opcode to ALU
- alu_result  in  64  ALU result C
- wb_valid  out  1  writeback beat present
- wb_ready  in  1  writeback sink accepts
- wb_sel  out  1  0 = LO/Rz beat, 1 = HI beat
- wb_data  out  32  writeback data
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on illegal opcode

Behaviour:
- Reset (clr=1, async):
  - State goes to IDLE.
  - Y, B, Z, op and wait counter clear to 0.
  - Outputs: alu_a=0, alu_b=0, alu_opcode=0, wb_valid=0, wb_sel=0, wb_data=0, busy=0, err=0.
  - req_ready goes to 1 on the first edge after clr deasserts.
- Legal opcode set: 00011, 00100, 00101, 00110, 00111, 01001, 01010, 01011, 01111, 10000, 10001, 10010. All other codes are illegal.
- States: IDLE, EXEC, CAPT, WB_LO, WB_HI, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_op, req_a into Y, req_b into B.
  - Legal opcode: go to EXEC and load the wait counter with ALU_WAIT.
  - Illegal opcode: go to ERR.
- EXEC:
  - Drive alu_a=Y, alu_b=B, alu_opcode=op.
  - Decrement the counter each cycle; go to CAPT when it reaches 1.
  - EXEC lasts exactly ALU_WAIT cycles.
- CAPT:
  - Keep driving the ALU inputs.
  - Z <= alu_result at the end of the cycle; go to WB_LO.
- WB_LO:
  - alu_* return to 0.
  - wb_valid=1, wb_sel=0, wb_data=Z[31:0].
  - Hold all three stable until wb_ready=1.
  - On the wb_valid & wb_ready handshake: go to WB_HI if op is OP_MUL or OP_DIV, else IDLE.
- WB_HI:
  - wb_valid=1, wb_sel=1, wb_data=Z[63:32].
  - Hold until wb_ready=1, then go to IDLE.
- ERR: err=1 for exactly one cycle, no ALU drive, no writeback; go to IDLE.
- Latency with ALU_WAIT=1 and wb_ready tied high, counting request acceptance as edge 0:
  - EXEC cycle 1, CAPT cycle 2.
  - First wb beat valid in cycle 3, second beat in cycle 4.
- Backpressure:
  - wb_ready may drop at any time; wb_valid/wb_sel/wb_data never change while a beat is unaccepted.
  - wb_ready is ignored when wb_valid=0.
- req_ready=0 in every state except IDLE. Requests presented then are not accepted and must be held by the requester.
- A request is accepted in the same cycle the sequencer returns to IDLE. No back-to-back overlap: the IDLE cycle always separates operations.
- Z is 64 bits and is not sign- or zero-adjusted. For single-beat ops, Z[63:32] is captured but never written back.
- clr asserted mid-operation (any state): abort immediately to the reset values; no partial writeback beat is completed.

Test Plan:
- Add (00011), A=5, B=7, ALU_WAIT=1, wb_ready=1 -> single beat wb_sel=0, wb_data=12 in cycle 3 after accept; busy low cycle 4.
- Mul (01111), A=0x00010000, B=0x00010000 -> beat 1 wb_sel=0 data=0x00000000; beat 2 wb_sel=1 data=0x00000001; then IDLE.
- Illegal op 5'b11111, A=1, B=1 -> err pulse exactly one cycle; no wb_valid; alu_opcode stays 0; req_ready back to 1 next cycle.
- Sub (00100), A=3, B=5, wb_ready held low 4 cycles -> wb_valid=1, wb_data=0xFFFFFFFE stable all 4 cycles; accepted on the first wb_ready=1 cycle.
- ALU_WAIT=4, Or (00110), A=0xF0, B=0x0F -> alu_* driven 5 cycles (4 EXEC + CAPT); wb_data=0xFF.
- clr asserted during WB_LO of a Div -> wb_valid drops asynchronously; no HI beat; req_ready=1 after clr deasserts.
